// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction fetch bus: ROM port, pipeline control and IF/ID slot
interface inst_fetch_if;
  logic [11:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        if_id_oob;
  logic        if_id_fault;

  // Fetch unit side
  modport master (
    output rom_addr,
    input  rom_inst,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_pc,
    output if_id_pc4,
    output if_id_inst,
    output if_id_oob,
    output if_id_fault
  );

  // ROM / decode / branch unit side
  modport slave (
    input  rom_addr,
    output rom_inst,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_pc,
    input  if_id_pc4,
    input  if_id_inst,
    input  if_id_oob,
    input  if_id_fault
  );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - single-issue instruction fetch stage with IF/ID register; optional misalign trap via IFETCH_MISALIGN_TRAP_EN
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_if.master      bus
);

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [29:0] ROM_WORDS_W = 30'(ROM_WORDS);

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   issued_q, issued_d;
  logic   fault_q, fault_d;
`endif

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_pc4_q, slot_pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        oob_q, oob_d;
  logic        fetch_oob;
  logic [31:0] fetch_inst;

  // Word index beyond the ROM returns a NOP flagged out-of-bounds
  always_comb begin
    fetch_oob  = (pc_q[31:2] >= ROM_WORDS_W);
    fetch_inst = fetch_oob ? NOP : bus.rom_inst;
  end

  // Next PC / IF/ID slot: redirect beats stall, stall beats advance
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    slot_pc_d  = slot_pc_q;
    slot_pc4_d = slot_pc4_q;
    inst_d     = inst_q;
    oob_d      = oob_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    state_d  = state_q;
    issued_d = issued_q;
    fault_d  = fault_q;
`endif
    if (bus.redirect_valid) begin
      valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_d     = bus.redirect_pc;
      issued_d = 1'b0;
      state_d  = (bus.redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
`else
      // Low bits dropped so the PC can never become misaligned
      pc_d = bus.redirect_pc & ~32'h3;
`endif
    end else if (!bus.stall) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (state_q == ST_FAULT) begin
        // One faulting slot reports the bad PC, then the stage goes quiet
        if (!issued_q) begin
          valid_d    = 1'b1;
          slot_pc_d  = pc_q;
          slot_pc4_d = pc_q + 32'd4;
          inst_d     = NOP;
          oob_d      = 1'b0;
          fault_d    = 1'b1;
          issued_d   = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end else
`endif
      begin
        valid_d    = 1'b1;
        slot_pc_d  = pc_q;
        slot_pc4_d = pc_q + 32'd4;
        inst_d     = fetch_inst;
        oob_d      = fetch_oob;
        pc_d       = pc_q + 32'd4;
`ifdef IFETCH_MISALIGN_TRAP_EN
        fault_d    = 1'b0;
`endif
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      slot_pc_q  <= 32'h0;
      slot_pc4_q <= 32'h0;
      inst_q     <= NOP;
      oob_q      <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_q    <= ST_RUN;
      issued_q   <= 1'b0;
      fault_q    <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      slot_pc_q  <= slot_pc_d;
      slot_pc4_q <= slot_pc4_d;
      inst_q     <= inst_d;
      oob_q      <= oob_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      state_q    <= state_d;
      issued_q   <= issued_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign bus.rom_addr    = pc_q[11:0];
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_pc    = slot_pc_q;
  assign bus.if_id_pc4   = slot_pc4_q;
  assign bus.if_id_inst  = inst_q;
  assign bus.if_id_oob   = oob_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign bus.if_id_fault = fault_q;
`else
  assign bus.if_id_fault = 1'b0;
`endif

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ROM_WORDS, default 128: number of valid 32-bit words in instruction ROM.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 rom_addr  output  12: byte address to instruction ROM; combinational copy of pc_q[11:0].
REQ-006 rom_inst  input  32: ROM read data; combinational, valid same cycle as rom_addr.
REQ-007 stall  input  1: downstream decode cannot accept; hold PC and IF/ID register.
REQ-008 redirect_valid  input  1: branch/jump taken; load redirect_pc.
REQ-009 redirect_pc  input  32: redirect target byte address.
REQ-010 if_id_valid  output  1: IF/ID slot holds a live instruction.
REQ-011 if_id_pc  output  32: PC of instruction in slot.
REQ-012 if_id_pc4  output  32: if_id_pc + 4, modulo 2^32.
REQ-013 if_id_inst  output  32: instruction word in slot.
REQ-014 if_id_oob  output  1: slot PC was outside ROM range; if_id_inst is NOP.
REQ-015 if_id_fault  output  1: slot PC misaligned (see Configuration).

Function
REQ-016 The block SHALL hold pc_q (32 bit) and an IF/ID register {valid, pc, pc4, inst, oob, fault}.
REQ-017 Event priority per cycle SHALL be reset > redirect_valid > stall > normal advance.
REQ-018 Normal advance: IF/ID <= {1, pc_q, pc_q+4, fetched word, oob, 0}; pc_q <= pc_q+4; one instruction per cycle, one-cycle latency from pc_q to if_id_*.
REQ-019 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-020 Fetched word SHALL be rom_inst when pc_q[31:2] < ROM_WORDS, else 32'h0000_0013 (NOP) with oob=1.
REQ-021 Stall (no redirect): pc_q and all IF/ID fields SHALL hold unchanged.
REQ-022 Redirect: pc_q <= redirect_pc, if_id_valid <= 0 (bubble), regardless of stall; other IF/ID fields don't-care.
REQ-023 Cycle after redirect SHALL fetch from redirect_pc; first valid slot carries if_id_pc == redirect_pc.
REQ-024 Redirect asserted on consecutive cycles: last target wins; if_id_valid stays 0 throughout.
REQ-025 FSM states RUN and FAULT; RUN is the only state without IFETCH_MISALIGN_TRAP_EN.
REQ-026 RUN -> FAULT on redirect with redirect_pc[1:0] != 0 (macro defined); FAULT -> RUN on redirect with aligned redirect_pc; otherwise stay.
REQ-027 In FAULT: first non-stalled cycle issues one slot {valid=1, pc=pc_q, inst=NOP, fault=1}, then if_id_valid=0 and pc_q frozen until leaving FAULT.

Reset
REQ-028 On reset: pc_q=RESET_PC, state=RUN, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_inst=32'h0000_0013, if_id_oob=0, if_id_fault=0.
REQ-029 Reset mid-stall or mid-redirect SHALL override both; first valid slot after reset release carries RESET_PC.

Configuration
REQ-030 Macro IFETCH_MISALIGN_TRAP_EN defined: misaligned redirect enters FAULT per REQ-026/027.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 2'b00 on load, FAULT state absent, if_id_fault tied 0.

Verification
REQ-032 Reset release, no stall, ROM[0..3]=A,B,C,D -> if_id_inst A,B,C,D on 4 consecutive cycles, if_id_pc 0,4,8,C, valid from 1st cycle after reset.
REQ-033 Stall high 3 cycles while slot holds pc=8 -> if_id_pc=8, inst=C held, rom_addr=12'h00C held; resumes with pc=C.
REQ-034 redirect_valid with redirect_pc=32'h40 while stall=1 -> next cycle valid=0; following cycle valid=1, if_id_pc=32'h40, inst=ROM[16].
REQ-035 Redirect to 32'h200 (word 128, ROM_WORDS=128) -> if_id_inst=32'h0000_0013, if_id_oob=1, if_id_pc4=32'h204.
REQ-036 With macro: redirect_pc=32'h42 -> one slot fault=1, inst=NOP, then valid=0 until redirect to 32'h44 yields valid slot pc=32'h44; without macro: same stimulus fetches pc=32'h40, fault=0.
REQ-037 Redirect to 32'hFFFF_FFFC -> slot pc4=32'h0, next pc_q=32'h0, oob=1 on first slot, oob=0 on next.
